// File: rtl/lfsr_chk_pkg.sv
// Shared definitions for the 130-bit uniform LFSR word-stream checker.
//   WORD_W/STATE_W : visible word width and full generator register width
//   TAP_A/TAP_B    : feedback taps of the recurrence next[i] = cur[i+7] ^ cur[i+10]
//   FB_SPAN        : bits below this index come from feedback, the rest are rotated
//   PREDICT_MASK   : bits 118/119 cleared; they depend on hidden generator bits 128/129
//   chk_state_t    : checker lock states
package lfsr_chk_pkg;

  localparam int WORD_W  = 128;
  localparam int STATE_W = 130;
  localparam int TAP_A   = 7;
  localparam int TAP_B   = 10;
  localparam int FB_SPAN = 120;

  localparam logic [WORD_W-1:0] PREDICT_MASK = {{8{1'b1}}, 2'b00, {118{1'b1}}};

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

endpackage

// File: rtl/lfsr_word_predict.sv
// Combinational next-word predictor for the 130-bit uniform LFSR.
// Ports:
//   prev     in  128  previous accepted word (generator bits [127:0])
//   prev2    in  128  word before prev; its bits [9:8] equal prev's hidden bits [129:128]
//   full_vld in  1    prev2 belongs to the current run, so bits 118/119 can be predicted
//   exp      out 128  predicted next word; bits 118/119 are 0 when full_vld is low
module lfsr_word_predict
  import lfsr_chk_pkg::*;
(
  input  logic [WORD_W-1:0] prev,
  input  logic [WORD_W-1:0] prev2,
  input  logic              full_vld,
  output logic [WORD_W-1:0] exp
);

  // Only the two bits that shadow the hidden generator state are needed from prev2.
  logic unused_prev2;
  assign unused_prev2 = ^{prev2[WORD_W-1:10], prev2[7:0]};

  always_comb begin
    exp = '0;
    for (int i = 0; i < FB_SPAN - 2; i++) begin
      exp[i] = prev[i+TAP_A] ^ prev[i+TAP_B];
    end
    // prev's hidden bits 128/129 were rotated in from prev2[8]/prev2[9].
    exp[FB_SPAN-2] = full_vld & (prev[FB_SPAN-2+TAP_A] ^ prev2[8]);
    exp[FB_SPAN-1] = full_vld & (prev[FB_SPAN-1+TAP_A] ^ prev2[9]);
    for (int i = FB_SPAN; i < WORD_W; i++) begin
      exp[i] = prev[i-FB_SPAN];
    end
  end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Receiver-side lock/error checker for the 128-bit uniform LFSR word stream.
// Predicts each word from the previous accepted word, locks after LOCK_CNT
// consecutive matches and drops lock after UNLOCK_CNT consecutive misses.
// Optional build macro LFSR_CHK_FULL_EN: reconstruct the hidden generator bits
// from the word before last and compare all 128 bits once that history is valid.
// Ports:
//   clk        in  1      clock
//   reset      in  1      synchronous, active-high
//   in_valid   in  1      in_data carries a new word (no backpressure)
//   in_data    in  128    generator word
//   locked     out 1      high while in LOCKED
//   err_pulse  out 1      one-cycle pulse per mismatching word while LOCKED
//   err_count  out ERR_W  saturating count of mismatches while LOCKED
//   word_count out 32     valid words accepted since reset, wrapping
module lfsr_stream_checker
  import lfsr_chk_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [31:0]       word_count
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  chk_state_t        state, state_nxt;
  logic [7:0]        match_cnt, match_nxt;
  logic [7:0]        miss_cnt, miss_nxt;
  logic [WORD_W-1:0] prev, prev2;
  logic [WORD_W-1:0] exp_word;
  logic [WORD_W-1:0] cmp_mask;
  logic              full_vld;
  logic              match;
  logic              err_pulse_nxt;
  logic [ERR_W-1:0]  err_count_nxt;
  logic [31:0]       word_count_nxt;

  lfsr_word_predict u_predict (
    .prev     (prev),
    .prev2    (prev2),
    .full_vld (full_vld),
    .exp      (exp_word)
  );

`ifdef LFSR_CHK_FULL_EN
  // Words of history in the current run; prev2 is trustworthy at 2. The run
  // restarts whenever match_cnt is cleared (entering CHECK or a CHECK miss).
  logic [1:0] hist_cnt;
  logic       hist_clr;

  assign hist_clr = (state_nxt == CHECK) && !((state == CHECK) && match);

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_cnt <= '0;
    end else if (in_valid) begin
      hist_cnt <= hist_clr ? 2'd1 : ((hist_cnt == 2'd2) ? 2'd2 : hist_cnt + 2'd1);
    end
  end

  assign full_vld = (hist_cnt == 2'd2);
`else
  assign full_vld = 1'b0;
`endif

  assign cmp_mask = full_vld ? '1 : PREDICT_MASK;
  assign match    = (((in_data ^ exp_word) & cmp_mask) == '0);

  always_comb begin
    state_nxt      = state;
    match_nxt      = match_cnt;
    miss_nxt       = miss_cnt;
    err_pulse_nxt  = 1'b0;
    err_count_nxt  = err_count;
    word_count_nxt = word_count;
    if (in_valid) begin
      word_count_nxt = word_count + 32'd1;
      case (state)
        HUNT: begin
          state_nxt = CHECK;
          match_nxt = '0;
        end
        CHECK: begin
          if (match) begin
            match_nxt = match_cnt + 8'd1;
            if (match_nxt == 8'(LOCK_CNT)) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            // Resync on this word; misses before lock are not errors.
            match_nxt = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_nxt = '0;
          end else begin
            err_pulse_nxt = 1'b1;
            err_count_nxt = sat_inc(err_count);
            miss_nxt      = miss_cnt + 8'd1;
            if (miss_nxt == 8'(UNLOCK_CNT)) begin
              state_nxt = CHECK;
              match_nxt = '0;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Register stage: state, counters, outputs and word history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      prev       <= '0;
      prev2      <= '0;
    end else begin
      state      <= state_nxt;
      match_cnt  <= match_nxt;
      miss_cnt   <= miss_nxt;
      locked     <= (state_nxt == LOCKED);
      err_pulse  <= err_pulse_nxt;
      err_count  <= err_count_nxt;
      word_count <= word_count_nxt;
      if (in_valid) begin
        prev  <= in_data;
        prev2 <= prev;
      end
    end
  end

endmodule
